inst_mem_resp: RTL

//   Instruction-memory responder on the core's fetch interface: samples the

---
 rtl/inst_mem_resp.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/inst_mem_resp.sv
// Instruction-memory responder: a LOAD phase fills the array over a valid/ready port,
// then RUN serves registered fetches. Optional fetch counter under IMEM_FETCH_CNT_EN.
module inst_mem_resp #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_o,
  output logic        fetch_err_o,
  input  logic        ld_valid_i,
  output logic        ld_ready_o,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_data_i,
  input  logic        ld_done_i,
  output logic        ld_err_o,
  output logic        run_o
`ifdef IMEM_FETCH_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o
`endif
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [32:0] LIMIT_OFF = 33'(4 * DEPTH);

  typedef enum logic {
    S_LOAD,
    S_RUN
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [31:0]   r_mem [DEPTH];
  logic          r_wr_en;
  logic [AW-1:0] r_wr_idx;
  logic [31:0]   r_wr_data;

  logic [31:0]   r_inst;
  logic          r_fetch_err;
  logic          r_ld_err;

  logic [32:0]   w_ld_off;
  logic          w_ld_ok;
  logic          w_ld_xfer;
  logic [AW-1:0] w_ld_idx;

  logic [32:0]   w_fetch_off;
  logic          w_fetch_ok;
  logic [AW-1:0] w_fetch_idx;
  logic [31:0]   w_fetch_word;

  // 33-bit offsets: an address below BASE_ADDR borrows into bit 32 and fails the limit
  assign w_ld_off    = {1'b0, ld_addr_i} - {1'b0, BASE_ADDR};
  assign w_ld_ok     = (ld_addr_i[1:0] == 2'b00) && (w_ld_off < LIMIT_OFF);
  assign w_ld_idx    = w_ld_off[AW+1:2];
  assign w_ld_xfer   = ld_valid_i && ld_ready_o;

  assign w_fetch_off = {1'b0, inst_addr_i} - {1'b0, BASE_ADDR};
  assign w_fetch_ok  = (inst_addr_i[1:0] == 2'b00) && (w_fetch_off < LIMIT_OFF);
  assign w_fetch_idx = w_fetch_off[AW+1:2];

  // Writes land one cycle late; the pending word is forwarded so a fetch right after
  // the final load (same cycle as ld_done_i) still sees it.
  assign w_fetch_word = (r_wr_en && (r_wr_idx == w_fetch_idx)) ? r_wr_data : r_mem[w_fetch_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LOAD:  if (ld_done_i) w_state_next = S_RUN;
      S_RUN:   w_state_next = S_RUN;
      default: w_state_next = S_LOAD;
    endcase
  end

  always_comb begin
    ld_ready_o = 1'b0;
    run_o      = 1'b0;
    case (r_state)
      S_LOAD:  ld_ready_o = 1'b1;
      S_RUN:   run_o      = 1'b1;
      default: ld_ready_o = 1'b1;
    endcase
  end

  // Staged write request; reset clears it so a write caught by reset never reaches the array
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_en   <= 1'b0;
      r_wr_idx  <= '0;
      r_wr_data <= '0;
      r_ld_err  <= 1'b0;
    end else begin
      r_wr_en   <= w_ld_xfer && w_ld_ok;
      r_wr_idx  <= w_ld_idx;
      r_wr_data <= ld_data_i;
      r_ld_err  <= w_ld_xfer && !w_ld_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (r_wr_en) begin
      r_mem[r_wr_idx] <= r_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inst      <= NOP_INST;
      r_fetch_err <= 1'b0;
    end else if (r_state != S_RUN) begin
      r_inst      <= NOP_INST;
      r_fetch_err <= 1'b0;
    end else if (w_fetch_ok) begin
      r_inst      <= w_fetch_word;
      r_fetch_err <= 1'b0;
    end else begin
      r_inst      <= NOP_INST;
      r_fetch_err <= 1'b1;
    end
  end

  assign inst_o      = r_inst;
  assign fetch_err_o = r_fetch_err;
  assign ld_err_o    = r_ld_err;

`ifdef IMEM_FETCH_CNT_EN
  logic [31:0] r_fetch_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_cnt <= '0;
    end else if ((r_state == S_RUN) && w_fetch_ok) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign fetch_cnt_o = r_fetch_cnt;
`endif

endmodule
